// File: rtl/vga_pixel_write_buffer_pkg.sv
// Shared screen geometry, framebuffer entry layout and the pixel-to-address helper
// for the VGA pixel write buffer.
package vga_pixel_write_buffer_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int ADDR_W       = 15;
  localparam int COLOR_W      = 3;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int ROW_SHIFT_HI = 7;
  localparam int ROW_SHIFT_LO = 5;
  localparam int ENTRY_W      = ADDR_W + COLOR_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // y*160 = y*128 + y*32, so the row stride needs no multiplier.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << ROW_SHIFT_HI) + (yw << ROW_SHIFT_LO) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_pixel_write_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers and a registered full flag.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = full_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_q || pop_ok);

  // Head is forced to zero when empty so stale array contents never leak out.
  assign dout_o = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = push_ok ? wr_q + (PW+1)'(1) : wr_q;
    rd_d = pop_ok  ? rd_q + (PW+1)'(1) : rd_q;
    full_d = (wr_d[PW] != rd_d[PW]) && (wr_d[PW-1:0] == rd_d[PW-1:0]);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/vga_pixel_write_buffer.sv
// Converts the drawer's plot stream into framebuffer writes: range check and address
// register, then a FIFO draining into the video memory port under mem_ready.
module vga_pixel_write_buffer
  import vga_pixel_write_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               plot_i,
  input  logic [X_W-1:0]     x_i,
  input  logic [Y_W-1:0]     y_i,
  input  logic [COLOR_W-1:0] color_i,
  input  logic               mem_ready_i,
  output logic               mem_wr_en_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [COLOR_W-1:0] mem_data_o,
  output logic               fifo_full_o,
  output logic               overflow_o,
  output logic [7:0]         oob_count_o
);

  localparam logic [X_W-1:0] X_LIMIT = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(SCREEN_H);

  logic               s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic [COLOR_W-1:0] s1_color_q, s1_color_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         oob_q, oob_d;

  logic   in_range, pop, fifo_full, fifo_empty;
  pixel_t head;

  assign in_range = (x_i < X_LIMIT) && (y_i < Y_LIMIT);
  assign pop      = mem_wr_en_o && mem_ready_i;

  always_comb begin
    s1_valid_d = 1'b0;
    s1_addr_d  = s1_addr_q;
    s1_color_d = s1_color_q;
    oob_d      = oob_q;
    overflow_d = overflow_q;
    if (plot_i) begin
      if (in_range) begin
        s1_valid_d = 1'b1;
        s1_addr_d  = pixel_addr(x_i, y_i);
        s1_color_d = color_i;
      end else if (oob_q != 8'hFF) begin
        oob_d = oob_q + 8'd1;
      end
    end
    // A pop in the same cycle frees the slot, so only a full FIFO with no pop drops.
    if (s1_valid_q && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_color_q <= '0;
      overflow_q <= 1'b0;
      oob_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_color_q <= s1_color_d;
      overflow_q <= overflow_d;
      oob_q      <= oob_d;
    end
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .push_i (s1_valid_q),
    .pop_i  (pop),
    .din_i  ({s1_addr_q, s1_color_q}),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign mem_wr_en_o = !fifo_empty;
  assign mem_addr_o  = head.addr;
  assign mem_data_o  = head.color;
  assign fifo_full_o = fifo_full;
  assign overflow_o  = overflow_q;
  assign oob_count_o = oob_q;

endmodule

// File: tb/tb_vga_pixel_write_buffer.sv
// Randomised bench for vga_pixel_write_buffer: a queue-based reference model predicts
// accepted pixels into a scoreboard that a negedge monitor checks against memory writes.
module tb_vga_pixel_write_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        plot = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  color = '0;
  logic        mem_ready = 1'b0;
  logic        mem_wr_en;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  oob_count;

  always #5 clk = ~clk;

  vga_pixel_write_buffer #(.DEPTH(DEPTH)) dut (
    .clock_i    (clk),
    .reset_i    (reset),
    .plot_i     (plot),
    .x_i        (x),
    .y_i        (y),
    .color_i    (color),
    .mem_ready_i(mem_ready),
    .mem_wr_en_o(mem_wr_en),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .fifo_full_o(fifo_full),
    .overflow_o (overflow),
    .oob_count_o(oob_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  // Reference model: pixels are {address, color} pairs held as plain integers.
  int   mq[$];
  int   sb[$];
  bit   m_s1_v;
  int   m_s1;
  bit   m_ovf;
  int   m_oob;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted memory write must match the oldest predicted pixel.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1 && mem_ready === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        int e;
        e = sb.pop_front();
        check("write_addr", int'(mem_addr), e / 8);
        check("write_data", int'(mem_data), e % 8);
      end
    end
  end

  task automatic cyc(input bit rst, input bit p, input int xx, input int yy,
                     input int cc, input bit rdy);
    bit pop;
    reset = rst; plot = p; x = 8'(xx); y = 7'(yy); color = 3'(cc); mem_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete(); sb.delete();
      m_s1_v = 0; m_ovf = 0; m_oob = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (m_s1_v) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(m_s1);
          sb.push_back(m_s1);
        end else begin
          m_ovf = 1;
        end
      end
      m_s1_v = 0;
      if (p) begin
        if (xx < 160 && yy < 120) begin
          m_s1_v = 1;
          m_s1   = (yy * 160 + xx) * 8 + cc;
        end else if (m_oob < 255) begin
          m_oob++;
        end
      end
    end
    #1;
    check("mem_wr_en", int'(mem_wr_en), int'(mq.size() > 0));
    check("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
    check("overflow", int'(overflow), int'(m_ovf));
    check("oob_count", int'(oob_count), m_oob);
    if (mq.size() > 0) check("head_addr", int'(mem_addr), mq[0] / 8);
    else               check("idle_addr", int'(mem_addr), 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    int w0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Single pixel: address 2*160+5 = 325, data 5.
    w0 = n_writes;
    cyc(0, 1, 5, 2, 5, 1);
    idle(5, 1);
    check("single_writes", n_writes - w0, 1);

    // 4x4 square at (10,20).
    w0 = n_writes;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cyc(0, 1, 10 + c, 20 + r, (r * 4 + c) % 8, 1);
    idle(6, 1);
    check("burst_writes", n_writes - w0, 16);

    // Full FIFO with simultaneous push and pop: no drop.
    for (int i = 0; i < 8; i++) cyc(0, 1, i, 50, i, 0);
    idle(2, 0);
    w0 = n_writes;
    for (int i = 0; i < 10; i++) cyc(0, 1, 20 + i, 60, i % 8, 1);
    idle(12, 1);
    check("fullpp_writes", n_writes - w0, 18);

    // Stall with 12 plots: first 8 kept, rest dropped, overflow sticks.
    for (int i = 0; i < 12; i++) cyc(0, 1, 100 + i, 70, (i + 3) % 8, 0);
    idle(3, 0);
    w0 = n_writes;
    idle(12, 1);
    check("stall_writes", n_writes - w0, 8);

    // Out-of-range pixels then saturation.
    w0 = n_writes;
    cyc(0, 1, 160, 0, 1, 1);
    cyc(0, 1, 0, 120, 2, 1);
    idle(1, 1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) cyc(0, 1, $urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7), 1);
      else                           cyc(0, 1, $urandom_range(0, 255), $urandom_range(120, 127), $urandom_range(0, 7), 1);
    end
    idle(3, 1);
    check("oob_writes", n_writes - w0, 0);

    // Reset with 5 entries buffered; nothing stale may appear afterwards.
    for (int i = 0; i < 5; i++) cyc(0, 1, i, 9, i, 0);
    idle(2, 0);
    cyc(1, 0, 0, 0, 0, 0);
    w0 = n_writes;
    idle(6, 1);
    check("post_reset_writes", n_writes - w0, 0);

    // Random mix.
    for (int i = 0; i < 600; i++) begin
      int xx, yy;
      if ($urandom_range(0, 99) < 88) begin
        xx = $urandom_range(0, 159); yy = $urandom_range(0, 119);
      end else begin
        xx = $urandom_range(150, 255); yy = $urandom_range(110, 127);
      end
      cyc(0, ($urandom_range(0, 9) < 7), xx, yy, $urandom_range(0, 7), ($urandom_range(0, 9) < 6));
    end
    idle(20, 1);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
